// File: rtl/analog_lim_mon.sv
// analog_lim_mon: per-channel A2D limit monitor with persistence filtering, exit hysteresis, sticky flags and irq
module analog_lim_mon #(
  parameter int NCH = 4,
  parameter int W = 12,
  parameter int PERSIST = 8,
  parameter logic [W-1:0] HYST = 'h040,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             smpl_vld,
  input  logic [CW-1:0]    smpl_ch,
  input  logic [W-1:0]     smpl,
  input  logic [NCH*W-1:0] thr_lo,
  input  logic [NCH*W-1:0] thr_hi,
  input  logic             clr,
  output logic [NCH-1:0]   lo_flag,
  output logic [NCH-1:0]   hi_flag,
  output logic [NCH-1:0]   sticky_lo,
  output logic [NCH-1:0]   sticky_hi,
  output logic             irq
);
  typedef enum logic [2:0] {OK, PEND_LO, LOW, PEND_HI, HIGH} state_t;
  logic [NCH-1:0] lo_d, hi_d, lo_q, hi_q, slo_q, shi_q, enter_lo, enter_hi;
  logic irq_q;
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic [W-1:0] lo, hi, exit_lo, exit_hi;
    logic [W:0] lo_sum;
    logic sel, below, above, persist_hit;
    assign lo = thr_lo[k*W +: W];
    assign hi = thr_hi[k*W +: W];
    assign sel = smpl_vld && smpl_ch == CW'(k);
    assign below = smpl < lo;
    assign above = smpl > hi;
    // exit points saturate instead of wrapping so the band never inverts
    assign lo_sum = {1'b0, lo} + {1'b0, HYST};
    assign exit_lo = lo_sum[W] ? '1 : lo_sum[W-1:0];
    assign exit_hi = (hi < HYST) ? '0 : hi - HYST;
    assign cnt_inc = cnt_q + 8'd1;
    assign persist_hit = cnt_inc == 8'(PERSIST);
    always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      if (sel) begin
        unique case (state_q)
          OK: begin
            state_d = above ? PEND_HI : below ? PEND_LO : OK;
            cnt_d = (above || below) ? 8'd1 : 8'd0;
          end
          PEND_LO: begin
            state_d = above ? PEND_HI : !below ? OK : persist_hit ? LOW : PEND_LO;
            cnt_d = above ? 8'd1 : below ? cnt_inc : 8'd0;
          end
          PEND_HI: begin
            state_d = above ? (persist_hit ? HIGH : PEND_HI) : below ? PEND_LO : OK;
            cnt_d = above ? cnt_inc : below ? 8'd1 : 8'd0;
          end
          LOW: begin
            state_d = above ? PEND_HI : (smpl >= exit_lo) ? OK : LOW;
            cnt_d = above ? 8'd1 : 8'd0;
          end
          HIGH: begin
            state_d = below ? PEND_LO : (smpl <= exit_hi) ? OK : HIGH;
            cnt_d = below ? 8'd1 : 8'd0;
          end
          default: begin
            state_d = OK;
            cnt_d = 8'd0;
          end
        endcase
      end
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= OK;
        cnt_q <= '0;
      end else begin
        state_q <= state_d;
        cnt_q <= cnt_d;
      end
    end
    assign lo_d[k] = state_d == LOW;
    assign hi_d[k] = state_d == HIGH;
  end
  assign enter_lo = lo_d & ~lo_q;
  assign enter_hi = hi_d & ~hi_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
      slo_q <= '0;
      shi_q <= '0;
      irq_q <= 1'b0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
      slo_q <= (clr ? '0 : slo_q) | enter_lo;
      shi_q <= (clr ? '0 : shi_q) | enter_hi;
      irq_q <= |{enter_lo, enter_hi};
    end
  end
  assign lo_flag = lo_q;
  assign hi_flag = hi_q;
  assign sticky_lo = slo_q;
  assign sticky_hi = shi_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_analog_lim_mon.sv
// tb_analog_lim_mon: directed vectors for analog_lim_mon with hand-computed expectations
module tb_analog_lim_mon;
  localparam int W = 12;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic vld = 0, clr = 0;
  logic [1:0] ch = 0;
  logic [W-1:0] smpl = 0;
  logic [4*W-1:0] thr_lo, thr_hi;
  logic [3:0] lo_flag, hi_flag, sticky_lo, sticky_hi;
  logic irq;
  logic vld3 = 0;
  logic [1:0] ch3 = 0;
  logic [W-1:0] s3 = 0;
  logic [3*W-1:0] thr_lo3, thr_hi3;
  logic [2:0] lo3, hi3, slo3, shi3;
  logic irq3;
  int n_chk = 0, n_err = 0, irqs = 0, irqs3 = 0;
  analog_lim_mon #(.NCH(4), .W(W), .PERSIST(4), .HYST('h040)) dut (
    .clk(clk), .rst(rst), .smpl_vld(vld), .smpl_ch(ch), .smpl(smpl),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .clr(clr),
    .lo_flag(lo_flag), .hi_flag(hi_flag), .sticky_lo(sticky_lo), .sticky_hi(sticky_hi), .irq(irq)
  );
  analog_lim_mon #(.NCH(3), .W(W), .PERSIST(4), .HYST('h040)) dut3 (
    .clk(clk), .rst(rst), .smpl_vld(vld3), .smpl_ch(ch3), .smpl(s3),
    .thr_lo(thr_lo3), .thr_hi(thr_hi3), .clr(1'b0),
    .lo_flag(lo3), .hi_flag(hi3), .sticky_lo(slo3), .sticky_hi(shi3), .irq(irq3)
  );
  always @(posedge clk) begin
    #1;
    if (irq) irqs++;
    if (irq3) irqs3++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic smp(input logic [1:0] c, input logic [W-1:0] v, input logic cl = 1'b0);
    vld = 1;
    ch = c;
    smpl = v;
    clr = cl;
    @(negedge clk);
    vld = 0;
    clr = 0;
  endtask
  task automatic smpn(input logic [1:0] c, input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) smp(c, v);
  endtask
  initial begin
    thr_lo = {4{12'h800}};
    thr_hi = {4{12'hE00}};
    thr_lo3 = {3{12'h800}};
    thr_hi3 = {3{12'hE00}};
    repeat (2) @(negedge clk);
    check("reset_flags", {lo_flag, hi_flag}, 0);
    check("reset_sticky", {sticky_lo, sticky_hi}, 0);
    check("reset_irq", irq, 0);
    rst = 0;
    @(negedge clk);
    smpn(0, 'h7FF, 3);
    smp(0, 'h900);
    check("ch0_interrupted", lo_flag, 0);
    smpn(0, 'h7FF, 3);
    check("ch0_restart_noflag", lo_flag, 0);
    check("ch0_no_irq", irqs, 0);
    smp(0, 'h900);
    smpn(1, 'h7FF, 3);
    check("ch1_pend", lo_flag, 0);
    smp(1, 'h7FF);
    check("ch1_low", lo_flag, 4'b0010);
    check("ch1_sticky", sticky_lo, 4'b0010);
    check("ch1_irq", irq, 1);
    smp(1, 'h820);
    check("ch1_hyst_stay", lo_flag, 4'b0010);
    check("ch1_irq_once", irqs, 1);
    smp(1, 'h840);
    check("ch1_exit", lo_flag, 0);
    check("ch1_sticky_kept", sticky_lo, 4'b0010);
    smpn(2, 'h7FF, 4);
    check("ch2_low", lo_flag, 4'b0100);
    smp(2, 'hF00);
    check("ch2_pend_hi", {lo_flag, hi_flag}, 0);
    smpn(2, 'hF00, 2);
    check("ch2_pend_hi2", hi_flag, 0);
    smp(2, 'hF00);
    check("ch2_high", hi_flag, 4'b0100);
    check("ch2_irq", irq, 1);
    check("ch2_sticky_hi", sticky_hi, 4'b0100);
    smp(2, 'hDC1);
    check("ch2_hyst_stay", hi_flag, 4'b0100);
    smp(2, 'hDC0);
    check("ch2_hyst_exit", hi_flag, 0);
    check("irq_count3", irqs, 3);
    thr_lo[3*W +: W] = 'h000;
    thr_hi[3*W +: W] = 'h030;
    smpn(3, 'h100, 4);
    check("ch3_high", hi_flag, 4'b1000);
    smp(3, 'h001);
    check("ch3_sat0_stay", hi_flag, 4'b1000);
    smp(3, 'h000);
    check("ch3_sat0_exit", hi_flag, 0);
    thr_lo[3*W +: W] = 'hFF0;
    thr_hi[3*W +: W] = 'hFFF;
    smpn(3, 'hFEF, 4);
    check("ch3_low", lo_flag, 4'b1000);
    smp(3, 'hFFE);
    check("ch3_satmax_stay", lo_flag, 4'b1000);
    smp(3, 'hFFF);
    check("ch3_satmax_exit", lo_flag, 0);
    check("irq_count5", irqs, 5);
    thr_lo[3*W +: W] = 'h800;
    thr_hi[3*W +: W] = 'hE00;
    check("sticky_accum", {sticky_lo, sticky_hi}, 8'b1110_1100);
    smpn(0, 'h7FF, 3);
    smp(0, 'h7FF, 1'b1);
    check("clr_set_wins", {sticky_lo, sticky_hi}, 8'b0001_0000);
    check("clr_ch0_low", lo_flag, 4'b0001);
    clr = 1;
    @(negedge clk);
    clr = 0;
    check("clr_alone", {sticky_lo, sticky_hi}, 0);
    check("clr_keeps_flag", lo_flag, 4'b0001);
    smp(0, 'h900);
    check("ch0_exit", lo_flag, 0);
    smpn(2, 'h7FF, 3);
    #2 rst = 1;
    #1 check("async_rst", {lo_flag, hi_flag, sticky_lo, sticky_hi, irq}, 0);
    #1 rst = 0;
    @(negedge clk);
    smp(2, 'h7FF);
    check("rst_discard1", lo_flag, 0);
    smpn(2, 'h7FF, 2);
    check("rst_discard3", lo_flag, 0);
    smp(2, 'h7FF);
    check("rst_restart_low", lo_flag, 4'b0100);
    irqs3 = 0;
    for (int i = 0; i < 8; i++) begin
      vld3 = 1;
      ch3 = 3;
      s3 = 'h000;
      @(negedge clk);
    end
    vld3 = 0;
    check("nch3_oob", {lo3, hi3, slo3, shi3}, 0);
    check("nch3_oob_irq", irqs3, 0);
    for (int i = 0; i < 4; i++) begin
      vld3 = 1;
      ch3 = 2;
      s3 = 'h000;
      @(negedge clk);
    end
    vld3 = 0;
    check("nch3_ch2_low", lo3, 3'b100);
    check("nch3_irq", irqs3, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
